// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into CHUNK-bit slices,
// one register stage per slice, with a valid/ready handshake and status flags.
module addsub_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic             input_carry,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] output_sum,
  output logic             output_carry,
  output logic             flag_ovf,
  output logic             flag_zero,
  output logic             flag_neg
);

  localparam int unsigned STAGES = WIDTH / CHUNK;
  localparam int unsigned MSB    = WIDTH - 1;

  // Per-stage registers: operand A, inverted-or-not operand B, partial sum, slice carry.
  logic [STAGES-1:0]            v_q, v_d;
  logic [STAGES-1:0]            c_q, c_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
  logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
  logic [STAGES-1:0][WIDTH-1:0] s_q, s_d;

  // Stage inputs: stage 0 sees the ports, stage k sees the registers of stage k-1.
  logic [STAGES-1:0]            v_in;
  logic [STAGES-1:0]            c_in;
  logic [STAGES-1:0][WIDTH-1:0] a_in;
  logic [STAGES-1:0][WIDTH-1:0] b_in;
  logic [STAGES-1:0][WIDTH-1:0] s_in;

  logic             adv;
  logic [CHUNK:0]   slice_sum;

  assign adv      = !v_q[STAGES-1] | out_ready;
  assign in_ready = adv;

  always_comb begin
    v_in    = '0;
    c_in    = '0;
    a_in    = '0;
    b_in    = '0;
    s_in    = '0;
    v_in[0] = in_valid;
    c_in[0] = input_carry;
    a_in[0] = input_a;
    b_in[0] = op_sub ? ~input_b : input_b;
    for (int k = 1; k < STAGES; k++) begin
      v_in[k] = v_q[k-1];
      c_in[k] = c_q[k-1];
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
    end
  end

  // Data registers only load on a valid slot so the outputs hold across bubbles.
  always_comb begin
    v_d       = v_in;
    c_d       = c_q;
    a_d       = a_q;
    b_d       = b_q;
    s_d       = s_q;
    slice_sum = '0;
    for (int k = 0; k < STAGES; k++) begin
      slice_sum = {1'b0, a_in[k][k*CHUNK +: CHUNK]} + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, c_in[k]};
      if (v_in[k]) begin
        a_d[k]                  = a_in[k];
        b_d[k]                  = b_in[k];
        s_d[k]                  = s_in[k];
        s_d[k][k*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
        c_d[k]                  = slice_sum[CHUNK];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
    end else if (adv) begin
      v_q <= v_d;
      c_q <= c_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
    end
  end

  assign out_valid    = v_q[STAGES-1];
  assign output_sum   = s_q[STAGES-1];
  assign output_carry = c_q[STAGES-1];
  assign flag_ovf     = (a_q[STAGES-1][MSB] == b_q[STAGES-1][MSB]) &
                        (s_q[STAGES-1][MSB] != a_q[STAGES-1][MSB]);
  assign flag_zero    = (s_q[STAGES-1] == '0);
  assign flag_neg     = s_q[STAGES-1][MSB];

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed self-checking bench for addsub_pipe at WIDTH=8, CHUNK=4 (latency 2).
module tb_addsub_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] input_a;
  logic [7:0] input_b;
  logic       input_carry;
  logic       op_sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] output_sum;
  logic       output_carry;
  logic       flag_ovf;
  logic       flag_zero;
  logic       flag_neg;

  int total = 0;
  int bad   = 0;

  addsub_pipe #(.WIDTH(8), .CHUNK(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .input_a      (input_a),
    .input_b      (input_b),
    .input_carry  (input_carry),
    .op_sub       (op_sub),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .output_sum   (output_sum),
    .output_carry (output_carry),
    .flag_ovf     (flag_ovf),
    .flag_zero    (flag_zero),
    .flag_neg     (flag_neg)
  );

  always #5 clk = ~clk;

  // Issue one op into an empty pipe and return {valid, sum, carry, ovf, zero, neg}
  // as seen two edges after it was presented.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sub, output logic [12:0] res);
    input_a     = a;
    input_b     = b;
    input_carry = cin;
    op_sub      = sub;
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    res = {out_valid, output_sum, output_carry, flag_ovf, flag_zero, flag_neg};
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    input_a = 8'hAA; input_b = 8'h55; input_carry = 1'b1; op_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({out_valid, output_sum, output_carry, flag_ovf, flag_neg} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b sum=%h c=%b ovf=%b neg=%b, want all 0",
               out_valid, output_sum, output_carry, flag_ovf, flag_neg);
    end
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL reset_ready: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_carry_sweep();
    logic [7:0]  va  [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0]  vb  [8] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};
    logic        vc  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    // {valid, sum, carry, ovf, zero, neg}
    logic [12:0] exp [8] = '{{1'b1, 8'h00, 4'b0010}, {1'b1, 8'h01, 4'b0000},
                             {1'b1, 8'hFF, 4'b0001}, {1'b1, 8'h00, 4'b1010},
                             {1'b1, 8'hFF, 4'b0001}, {1'b1, 8'h00, 4'b1010},
                             {1'b1, 8'hFE, 4'b1001}, {1'b1, 8'hFF, 4'b1001}};
    logic [12:0] res;
    for (int i = 0; i < 8; i++) begin
      do_op(va[i], vb[i], vc[i], 1'b0, res);
      total++;
      if (res !== exp[i]) begin
        bad++;
        $display("FAIL carry_sweep[%0d] %h+%h+%b: got %b, want %b",
                 i, va[i], vb[i], vc[i], res, exp[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [12:0] res;
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, res);
    total++;
    if (res !== {1'b1, 8'h80, 4'b0101}) begin
      bad++;
      $display("FAIL ovf_7F_01: got %b, want %b", res, {1'b1, 8'h80, 4'b0101});
    end
    do_op(8'h80, 8'hFF, 1'b0, 1'b0, res);
    total++;
    if (res !== {1'b1, 8'h7F, 4'b1100}) begin
      bad++;
      $display("FAIL ovf_80_FF: got %b, want %b", res, {1'b1, 8'h7F, 4'b1100});
    end
  endtask

  task automatic test_subtract();
    logic [12:0] res;
    do_op(8'h05, 8'h05, 1'b1, 1'b1, res);
    total++;
    if (res !== {1'b1, 8'h00, 4'b1010}) begin
      bad++;
      $display("FAIL sub_05_05: got %b, want %b", res, {1'b1, 8'h00, 4'b1010});
    end
    do_op(8'h03, 8'h05, 1'b1, 1'b1, res);
    total++;
    if (res !== {1'b1, 8'hFE, 4'b0001}) begin
      bad++;
      $display("FAIL sub_03_05: got %b, want %b", res, {1'b1, 8'hFE, 4'b0001});
    end
    // 80 - 01 = 7F overflows only because B is inverted before the sign test.
    do_op(8'h80, 8'h01, 1'b1, 1'b1, res);
    total++;
    if (res !== {1'b1, 8'h7F, 4'b1100}) begin
      bad++;
      $display("FAIL sub_80_01: got %b, want %b", res, {1'b1, 8'h7F, 4'b1100});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [8] = '{8'h0F, 8'h20, 8'h31, 8'h42, 8'h53, 8'h64, 8'h75, 8'h86};
    out_ready = 1'b1; input_b = 8'h0F; input_carry = 1'b0; op_sub = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      in_valid = (n <= 8);
      input_a  = 8'((n - 1) * 8'h11);
      @(posedge clk); #1;
      total++;
      if (out_valid !== (n >= 2 && n <= 9)) begin
        bad++;
        $display("FAIL stream_valid edge %0d: got %b, want %b", n, out_valid, n >= 2 && n <= 9);
      end
      if (n >= 2 && n <= 9) begin
        total++;
        if (output_sum !== exp[n-2]) begin
          bad++;
          $display("FAIL stream_sum[%0d]: got %h, want %h", n - 2, output_sum, exp[n-2]);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int         sent = 0;
    int         rcvd = 0;
    logic       acc, cons, stalled;
    logic [7:0] held_sum;
    logic       held_v;
    logic [7:0] exp [5] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    input_b = 8'h01; input_carry = 1'b0; op_sub = 1'b0;
    for (int n = 0; n < 16; n++) begin
      out_ready = !(n >= 4 && n <= 6);
      in_valid  = (sent < 5);
      input_a   = 8'(8'h20 + sent);
      #1;
      acc     = in_valid & in_ready;
      cons    = out_valid & out_ready;
      stalled = out_valid & !out_ready;
      if (stalled) begin
        total++;
        if (in_ready !== 1'b0) begin
          bad++;
          $display("FAIL bp_in_ready cycle %0d: got %b, want 0", n, in_ready);
        end
      end
      if (cons) begin
        total++;
        if (rcvd >= 5 || output_sum !== exp[rcvd % 5]) begin
          bad++;
          $display("FAIL bp_sum[%0d]: got %h, want %h", rcvd, output_sum, exp[rcvd % 5]);
        end
      end
      held_sum = output_sum;
      held_v   = out_valid;
      @(posedge clk); #1;
      if (stalled) begin
        total++;
        if ({out_valid, output_sum} !== {held_v, held_sum}) begin
          bad++;
          $display("FAIL bp_hold cycle %0d: got v=%b sum=%h, want v=%b sum=%h",
                   n, out_valid, output_sum, held_v, held_sum);
        end
      end
      if (acc) sent++;
      if (cons) rcvd++;
    end
    in_valid = 1'b0;
    total++;
    if (sent !== 5 || rcvd !== 5 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_count: got sent=%0d rcvd=%0d v=%b, want 5 5 0", sent, rcvd, out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1; op_sub = 1'b0; input_carry = 1'b0; input_b = 8'h01;
    in_valid = 1'b1;
    input_a = 8'h40;
    @(posedge clk); #1;
    input_a = 8'h50;
    @(posedge clk); #1;
    rst = 1'b1;
    input_a = 8'h60;
    @(posedge clk); #1;
    total++;
    if ({out_valid, output_sum} !== 9'h000) begin
      bad++;
      $display("FAIL rst_flight: got v=%b sum=%h, want v=0 sum=00", out_valid, output_sum);
    end
    rst = 1'b0; in_valid = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL rst_flight_leak cycle %0d: got v=%b sum=%h, want v=0",
                 n, out_valid, output_sum);
      end
    end
  endtask

  initial begin
    test_reset();
    test_carry_sweep();
    test_overflow();
    test_subtract();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
